// File: rtl/ser_arb_pkg.sv
// Shared types and defaults for the serializer arbiter.
// The FSM state encoding and the id-width helper live here.
package ser_arb_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned MOD_W_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  // Index width for n requesters, never narrower than one bit
  function automatic int unsigned id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ser_arbiter_rr_pick.sv
// Combinational round-robin selector.
// Picks the first set request at or after the pointer, wrapping modulo N.
module rr_pick
  import ser_arb_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = id_w(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] idx_o,
  output logic           any_o
);

  always_comb begin
    logic [IDW-1:0] k;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    k     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      k = IDW'((32'(ptr_i) + i) % N);
      if (!any_o && req_i[k]) begin
        any_o    = 1'b1;
        idx_o    = k;
        gnt_o[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ser_arbiter.sv
// Round-robin arbiter sharing one serializer between NUM_REQ word producers.
// Holds the issued word stable until the serializer drops busy; flags a serializer that never starts.
module ser_arbiter
  import ser_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned DATA_W        = DATA_W_DEF,
  parameter int unsigned MOD_W         = MOD_W_DEF,
  parameter int unsigned START_TIMEOUT = 4
) (
  input  logic                         clk_i,
  input  logic                         srst_i,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data_i,
  input  logic [NUM_REQ*MOD_W-1:0]     req_mod_i,
  input  logic [NUM_REQ-1:0]           req_val_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  output logic [DATA_W-1:0]            ser_data_o,
  output logic [MOD_W-1:0]             ser_mod_o,
  output logic                         ser_val_o,
  input  logic                         ser_busy_i,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id_o,
  output logic                         active_o,
  output logic                         err_o
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = 4;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [MOD_W-1:0]    mod_q, mod_d;
  logic                val_q, val_d;
  logic [ID_W-1:0]     gid_q, gid_d;
  logic                active_q, active_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [NUM_REQ-1:0]  pick_gnt;
  logic [ID_W-1:0]     pick_idx;
  logic                pick_any;
  logic [NUM_REQ-1:0]  ready_c;

  rr_pick #(
    .N   (NUM_REQ),
    .IDW (ID_W)
  ) u_rr_pick (
    .req_i (req_val_i),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Next-state, ready and payload capture
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    data_d   = data_q;
    mod_d    = mod_q;
    gid_d    = gid_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    val_d    = 1'b0;
    err_d    = 1'b0;
    ready_c  = '0;

    case (state_q)
      IDLE: begin
        if (!ser_busy_i && !srst_i && pick_any) ready_c = pick_gnt;
        if (|(req_val_i & ready_c)) begin
          data_d   = req_data_i[pick_idx*DATA_W +: DATA_W];
          mod_d    = req_mod_i[pick_idx*MOD_W +: MOD_W];
          gid_d    = pick_idx;
          ptr_d    = (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + ID_W'(1);
          val_d    = 1'b1;
          active_d = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (ser_busy_i) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
          // Serializer never acknowledged the start pulse
          err_d    = 1'b1;
          active_d = 1'b0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!ser_busy_i) begin
          active_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      data_q   <= '0;
      mod_q    <= '0;
      val_q    <= 1'b0;
      gid_q    <= '0;
      active_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      data_q   <= data_d;
      mod_q    <= mod_d;
      val_q    <= val_d;
      gid_q    <= gid_d;
      active_q <= active_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign req_ready_o = ready_c;
  assign ser_data_o  = data_q;
  assign ser_mod_o   = mod_q;
  assign ser_val_o   = val_q;
  assign grant_id_o  = gid_q;
  assign active_o    = active_q;
  assign err_o       = err_q;

endmodule
